// File: rtl/wb_openram_tester.sv
`default_nettype none
// ============================================================================
// Module      : wb_openram_tester
// Description : Wishbone master that walks NUM_WORDS words starting at
//               BASE_ADDR, writes an index-derived pattern to each, reads the
//               words back and reports mismatches, the first failing address
//               and a missing-acknowledge timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_openram_tester #(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter int          NUM_WORDS = 256,
  parameter int          TIMEOUT   = 15
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        start,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [3:0]  wbm_sel_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  input  logic [31:0] wbm_dat_i,
  input  logic        wbm_ack_i,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        timeout,
  output logic [15:0] err_count,
  output logic [31:0] fail_addr
);

  // Index of the final word and the stall limit, sized to the registers
  // they are compared against.
  localparam logic [15:0] C_LAST_IDX = 16'(NUM_WORDS - 1);
  localparam logic [7:0]  C_TIMEOUT  = 8'(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_READ  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t      state_q;
  logic [15:0] idx_q;
  logic [7:0]  wait_q;
  logic        cyc_q;
  logic        stb_q;
  logic        we_q;
  logic [3:0]  sel_q;
  logic [31:0] adr_q;
  logic [31:0] dat_q;
  logic        busy_q;
  logic        done_q;
  logic        pass_q;
  logic        timeout_q;
  logic [15:0] err_q;
  logic [31:0] fail_q;

  logic [15:0] err_d;
  logic [7:0]  wait_d;
  logic        mismatch;
  logic        last_word;
  logic        stall_expired;

  // Test pattern: upper half is the inverted index so that stuck or
  // shorted data lines show up on both halves of the word.
  function automatic logic [31:0] pattern(input logic [15:0] i);
    return {~i, i};
  endfunction

  // Byte address of word i, wrapping at 32 bits.
  function automatic logic [31:0] word_addr(input logic [15:0] i);
    return BASE_ADDR + {14'd0, i, 2'b00};
  endfunction

  // Read-back comparison, saturating error increment and stall limit check.
  always_comb begin
    mismatch      = (wbm_dat_i != pattern(idx_q));
    err_d         = (err_q == 16'hFFFF) ? err_q : err_q + 16'd1;
    last_word     = (idx_q == C_LAST_IDX);
    wait_d        = wait_q + 8'd1;
    stall_expired = (wait_d == C_TIMEOUT);
  end

  // Sequencer: launches one access at a time, inserts a single idle cycle
  // after every acknowledge and collects the results into held registers.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q   <= S_IDLE;
      idx_q     <= 16'd0;
      wait_q    <= 8'd0;
      cyc_q     <= 1'b0;
      stb_q     <= 1'b0;
      we_q      <= 1'b0;
      sel_q     <= 4'h0;
      adr_q     <= 32'd0;
      dat_q     <= 32'd0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      timeout_q <= 1'b0;
      err_q     <= 16'd0;
      fail_q    <= 32'd0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          // A new run clears every result and issues the first write at once.
          if (start) begin
            state_q   <= S_WRITE;
            idx_q     <= 16'd0;
            wait_q    <= 8'd0;
            cyc_q     <= 1'b1;
            stb_q     <= 1'b1;
            we_q      <= 1'b1;
            sel_q     <= 4'hF;
            adr_q     <= BASE_ADDR;
            dat_q     <= pattern(16'd0);
            busy_q    <= 1'b1;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
            timeout_q <= 1'b0;
            err_q     <= 16'd0;
            fail_q    <= 32'd0;
          end
        end

        S_WRITE, S_READ: begin
          if (stb_q) begin
            if (wbm_ack_i) begin
              // Access complete: release the bus for one cycle.
              cyc_q <= 1'b0;
              stb_q <= 1'b0;
              we_q  <= 1'b0;
              sel_q <= 4'h0;
              adr_q <= 32'd0;
              dat_q <= 32'd0;
              if ((state_q == S_READ) && mismatch) begin
                err_q <= err_d;
                if (err_q == 16'd0) begin
                  fail_q <= adr_q;
                end
              end
              if (last_word) begin
                idx_q <= 16'd0;
                if (state_q == S_WRITE) begin
                  state_q <= S_READ;
                end else begin
                  state_q <= S_DONE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  pass_q  <= (err_q == 16'd0) && !mismatch;
                end
              end else begin
                idx_q <= idx_q + 16'd1;
              end
            end else if (stall_expired) begin
              // Responder never answered: abandon the run.
              state_q   <= S_DONE;
              cyc_q     <= 1'b0;
              stb_q     <= 1'b0;
              we_q      <= 1'b0;
              sel_q     <= 4'h0;
              adr_q     <= 32'd0;
              dat_q     <= 32'd0;
              busy_q    <= 1'b0;
              done_q    <= 1'b1;
              pass_q    <= 1'b0;
              timeout_q <= 1'b1;
            end else begin
              wait_q <= wait_d;
            end
          end else begin
            // Idle gap over: start the access for the current index.
            cyc_q  <= 1'b1;
            stb_q  <= 1'b1;
            sel_q  <= 4'hF;
            adr_q  <= word_addr(idx_q);
            wait_q <= 8'd0;
            if (state_q == S_WRITE) begin
              we_q  <= 1'b1;
              dat_q <= pattern(idx_q);
            end else begin
              we_q  <= 1'b0;
              dat_q <= 32'd0;
            end
          end
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign wbm_cyc_o = cyc_q;
  assign wbm_stb_o = stb_q;
  assign wbm_we_o  = we_q;
  assign wbm_sel_o = sel_q;
  assign wbm_adr_o = adr_q;
  assign wbm_dat_o = dat_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign timeout   = timeout_q;
  assign err_count = err_q;
  assign fail_addr = fail_q;

endmodule
`default_nettype wire

// File: tb/tb_wb_openram_tester.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_openram_tester
// Description : Directed bench for wb_openram_tester with a 4-word RAM model
//               offering ack latency, read corruption and ack withholding.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_openram_tester;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        cyc, stb, we, ack;
  logic [3:0]  sel;
  logic [31:0] adr, dat_o, dat_i;
  logic        busy, done, pass, tmo;
  logic [15:0] err;
  logic [31:0] fail;

  int n_tests = 0;
  int n_fail  = 0;

  // RAM model controls
  int   latency    = 0;
  logic hold_en    = 1'b0;
  logic corrupt_en = 1'b0;
  int   lat_cnt    = 0;
  logic [31:0] mem [4];

  always #5 clk = ~clk;

  wb_openram_tester #(
    .BASE_ADDR(32'h3000_0000),
    .NUM_WORDS(4),
    .TIMEOUT  (15)
  ) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .start    (start),
    .wbm_cyc_o(cyc),
    .wbm_stb_o(stb),
    .wbm_we_o (we),
    .wbm_sel_o(sel),
    .wbm_adr_o(adr),
    .wbm_dat_o(dat_o),
    .wbm_dat_i(dat_i),
    .wbm_ack_i(ack),
    .busy     (busy),
    .done     (done),
    .pass     (pass),
    .timeout  (tmo),
    .err_count(err),
    .fail_addr(fail)
  );

  // RAM responder
  assign ack   = stb && (lat_cnt == latency) && !(hold_en && we && adr == 32'h3000_0004);
  assign dat_i = mem[adr[3:2]] ^ {31'd0, corrupt_en && (adr[3:2] == 2'd2)};

  always @(posedge clk) begin
    if (stb && !ack) lat_cnt <= lat_cnt + 1;
    else             lat_cnt <= 0;
    if (stb && ack && we) mem[adr[3:2]] <= dat_o;
  end

  // Bus monitor
  logic [31:0] q_adr[$];
  logic [31:0] q_wdat[$];
  logic        q_we[$];
  int          q_len[$];
  int   run_len = 0, last_run = 0;
  int   stab_err = 0, gap_err = 0, proto_err = 0;
  logic prev_stb = 1'b0, prev_we = 1'b0, prev_ackd = 1'b0, prev_low_busy = 1'b0;
  logic [31:0] prev_adr = 32'd0, prev_dat = 32'd0;

  always @(negedge clk) begin
    if (stb && prev_stb && (adr !== prev_adr || dat_o !== prev_dat || we !== prev_we))
      stab_err <= stab_err + 1;
    if ((prev_ackd && stb) || (busy && !stb && prev_low_busy))
      gap_err <= gap_err + 1;
    if ((stb && sel !== 4'hF) || (!stb && (sel !== 4'h0 || adr !== 32'd0)) || (!we && dat_o !== 32'd0))
      proto_err <= proto_err + 1;
    prev_low_busy <= busy && !stb;
    prev_stb  <= stb;
    prev_adr  <= adr;
    prev_dat  <= dat_o;
    prev_we   <= we;
    prev_ackd <= stb && ack;
    if (stb) run_len <= run_len + 1;
    else begin
      if (run_len != 0) last_run <= run_len;
      run_len <= 0;
    end
    if (stb && ack) begin
      q_adr.push_back(adr);
      q_we.push_back(we);
      q_wdat.push_back(dat_o);
      q_len.push_back(run_len + 1);
    end
  end

  int b_acc, b_stab, b_gap, b_proto;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic mark();
    b_acc   = q_adr.size();
    b_stab  = stab_err;
    b_gap   = gap_err;
    b_proto = proto_err;
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int k;
    for (k = 0; k < 3000 && !done; k++) @(negedge clk);
    check_eq({tag, "_done_seen"}, done, 1'b1);
    @(negedge clk);
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, "_cyc"},  cyc,   0);
    check_eq({tag, "_stb"},  stb,   0);
    check_eq({tag, "_we"},   we,    0);
    check_eq({tag, "_sel"},  sel,   0);
    check_eq({tag, "_adr"},  adr,   0);
    check_eq({tag, "_dat"},  dat_o, 0);
    check_eq({tag, "_busy"}, busy,  0);
    check_eq({tag, "_done"}, done,  0);
    check_eq({tag, "_pass"}, pass,  0);
    check_eq({tag, "_tmo"},  tmo,   0);
    check_eq({tag, "_err"},  err,   0);
    check_eq({tag, "_fail"}, fail,  0);
  endtask

  // Full 8-access run: 4 writes then 4 reads, each stb held exp_len cycles.
  task automatic check_full_run(input string tag, input int exp_len, input logic exp_pass,
                                input logic [15:0] exp_err, input logic [31:0] exp_fail);
    logic [31:0] pat [4];
    pat[0] = 32'hFFFF_0000;
    pat[1] = 32'hFFFE_0001;
    pat[2] = 32'hFFFD_0002;
    pat[3] = 32'hFFFC_0003;
    check_eq({tag, "_acc_count"}, q_adr.size() - b_acc, 8);
    if (q_adr.size() >= b_acc + 8) begin
      for (int i = 0; i < 8; i++) begin
        check_eq($sformatf("%s_we%0d", tag, i),  q_we[b_acc + i],  (i < 4));
        check_eq($sformatf("%s_adr%0d", tag, i), q_adr[b_acc + i], 32'h3000_0000 + 32'(4 * (i % 4)));
        check_eq($sformatf("%s_dat%0d", tag, i), q_wdat[b_acc + i], (i < 4) ? pat[i] : 32'd0);
        check_eq($sformatf("%s_len%0d", tag, i), q_len[b_acc + i], exp_len);
      end
    end
    check_eq({tag, "_stable"}, stab_err - b_stab, 0);
    check_eq({tag, "_gap"},    gap_err - b_gap, 0);
    check_eq({tag, "_proto"},  proto_err - b_proto, 0);
    check_eq({tag, "_done"},   done, 1);
    check_eq({tag, "_busy"},   busy, 0);
    check_eq({tag, "_cyc"},    cyc, 0);
    check_eq({tag, "_pass"},   pass, exp_pass);
    check_eq({tag, "_tmo"},    tmo, 0);
    check_eq({tag, "_err"},    err, exp_err);
    check_eq({tag, "_fail"},   fail, exp_fail);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_idle("reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check_idle("post_reset");

    // Basic zero-wait run
    mark(); pulse_start(); wait_done("basic");
    check_full_run("basic", 1, 1'b1, 16'd0, 32'd0);

    // Word 2 read back with bit 0 flipped, started from DONE
    corrupt_en = 1'b1;
    mark(); pulse_start(); wait_done("corrupt");
    check_full_run("corrupt", 1, 1'b0, 16'd1, 32'h3000_0008);
    corrupt_en = 1'b0;

    // Restart from DONE clears the previous results
    mark(); pulse_start(); wait_done("rerun");
    check_full_run("rerun", 1, 1'b1, 16'd0, 32'd0);

    // 3-cycle ack latency with a start pulse issued mid-run
    latency = 3;
    mark(); pulse_start();
    repeat (10) @(negedge clk);
    check_eq("lat3_busy_mid", busy, 1);
    pulse_start();
    wait_done("lat3");
    check_full_run("lat3", 4, 1'b1, 16'd0, 32'd0);

    // Ack arriving on the last permitted stall cycle still counts
    latency = 14;
    mark(); pulse_start(); wait_done("lat14");
    check_full_run("lat14", 15, 1'b1, 16'd0, 32'd0);

    // Ack withheld on write of word 1
    latency = 0;
    hold_en = 1'b1;
    mark(); pulse_start(); wait_done("hold");
    check_eq("hold_acc_count", q_adr.size() - b_acc, 1);
    check_eq("hold_stall_len", last_run, 15);
    check_eq("hold_done", done, 1);
    check_eq("hold_tmo",  tmo, 1);
    check_eq("hold_pass", pass, 0);
    check_eq("hold_busy", busy, 0);
    check_eq("hold_cyc",  cyc, 0);
    check_eq("hold_stb",  stb, 0);
    check_eq("hold_err",  err, 0);
    hold_en = 1'b0;

    // Reset during the read phase
    latency = 2;
    pulse_start();
    for (int k = 0; k < 300 && !(stb && !we); k++) @(negedge clk);
    check_eq("midread_found", stb && !we, 1'b1);
    rst = 1'b1;
    #1;
    check_idle("midread_rst");
    @(negedge clk) rst = 1'b0;
    repeat (4) @(negedge clk);
    check_idle("midread_after");
    latency = 0;
    mark(); pulse_start(); wait_done("after_rst");
    check_full_run("after_rst", 1, 1'b1, 16'd0, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
